display_mux7seg: RTL and testbench

Multiplexed, parametrised seven-segment display driver, the multi-digit successor of the single-digit BCD decoder. It holds a DIGITS-nibble display value and scans one digit at a time onto a shared common-anode segment bus with per-digit anode selects. It adds hexadecimal mode, leading-zero blanking, decimal points, a dead cycle between digits and tear-free frame-synchronous updates. It sits between the processor's output register and the board display.

---
 rtl/display_mux7seg_if.sv | 16 +
 rtl/display_mux7seg.sv | 146 ++++++++++++++
 tb/tb_display_mux7seg.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/display_mux7seg_if.sv
// Bundle of the display driver's control/data inputs and scanned display outputs.
interface display_mux7seg_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame;

  modport master (output en, load, value, dp_in, input seg, dp, an, frame);
  modport slave  (input en, load, value, dp_in, output seg, dp, an, frame);
endinterface

// File: rtl/display_mux7seg.sv
// Multiplexed common-anode seven-segment driver: scans DIGITS nibbles with a dead
// cycle per digit slot and swaps in new values only at frame boundaries.
module display_mux7seg #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned HEX_MODE = 0,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic              clock,
  input  logic              reset,
  display_mux7seg_if.slave  bus
);
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * DIGITS;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  disp_q, disp_d, shadow_q, shadow_d;
  logic [DIGITS-1:0] dpr_q, dpr_d, shadow_dp_q, shadow_dp_d;
  logic              pend_q, pend_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_q, frame_d;

  logic              cnt_wrap, idx_last, frame_end;
  logic [3:0]        nib;
  logic [DIGITS-1:0] zero_from;
  logic              blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = (HEX_MODE != 0) ? 7'b0001000 : 7'b1111111;
      4'hB: s = (HEX_MODE != 0) ? 7'b1100000 : 7'b1111111;
      4'hC: s = (HEX_MODE != 0) ? 7'b0110001 : 7'b1111111;
      4'hD: s = (HEX_MODE != 0) ? 7'b1000010 : 7'b1111111;
      4'hE: s = (HEX_MODE != 0) ? 7'b0110000 : 7'b1111111;
      default: s = (HEX_MODE != 0) ? 7'b0111000 : 7'b1111111;
    endcase
    return s;
  endfunction

  // Scan counters and frame-synchronous value update
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    disp_d      = disp_q;
    dpr_d       = dpr_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pend_d      = pend_q;

    cnt_wrap  = (cnt_q == CNT_W'(SCAN_DIV - 1));
    idx_last  = (idx_q == IDX_W'(DIGITS - 1));
    frame_end = cnt_wrap && idx_last;

    if (cnt_wrap) begin
      cnt_d = '0;
      idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    end

    if (frame_end) begin
      // A load arriving on the boundary itself beats anything still pending
      if (bus.load) begin
        disp_d = bus.value;
        dpr_d  = bus.dp_in;
        pend_d = 1'b0;
      end else if (pend_q) begin
        disp_d = shadow_q;
        dpr_d  = shadow_dp_q;
        pend_d = 1'b0;
      end
    end else if (bus.load) begin
      shadow_d    = bus.value;
      shadow_dp_d = bus.dp_in;
      pend_d      = 1'b1;
    end
  end

  // Digit selection, leading-zero detection and output pattern
  always_comb begin
    an_d    = '1;
    seg_d   = 7'b1111111;
    dp_d    = 1'b1;
    frame_d = (cnt_q == '0) && (idx_q == '0);

    nib = 4'(disp_q >> {idx_q, 2'b00});

    zero_from[DIGITS-1] = (disp_q[VAL_W-1 -: 4] == 4'h0);
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (disp_q[4*i +: 4] == 4'h0);
    end
    blank = (BLANK_LZ != 0) && (idx_q != '0) && zero_from[idx_q];

    if (bus.en && (cnt_q != '0)) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = blank ? 7'b1111111 : decode(nib);
      dp_d  = ~dpr_q[idx_q];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      dpr_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pend_q      <= 1'b0;
      an_q        <= '1;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      dpr_q       <= dpr_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pend_q      <= pend_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;
endmodule

// File: tb/tb_display_mux7seg.sv
// Scoreboard bench for display_mux7seg: two instances (plain decimal / hex with
// leading-zero blanking) share stimulus; a monitor checks whole frames against queued values.
module tb_display_mux7seg;
  logic        clock = 1'b0;
  logic        reset;
  logic        en, load;
  logic [15:0] value;
  logic [3:0]  dp_in;

  display_mux7seg_if #(.DIGITS(4)) bus_a ();
  display_mux7seg_if #(.DIGITS(4)) bus_b ();

  assign bus_a.en = en;  assign bus_a.load = load;  assign bus_a.value = value;  assign bus_a.dp_in = dp_in;
  assign bus_b.en = en;  assign bus_b.load = load;  assign bus_b.value = value;  assign bus_b.dp_in = dp_in;

  display_mux7seg #(.DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0), .BLANK_LZ(0)) u_a (
    .clock(clock), .reset(reset), .bus(bus_a));
  display_mux7seg #(.DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1), .BLANK_LZ(1)) u_b (
    .clock(clock), .reset(reset), .bus(bus_b));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpv;
    logic [15:0] off;   // frame positions where en is low
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n, input bit hex);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return hex ? 7'b0001000 : 7'b1111111;
      4'hB: return hex ? 7'b1100000 : 7'b1111111;
      4'hC: return hex ? 7'b0110001 : 7'b1111111;
      4'hD: return hex ? 7'b1000010 : 7'b1111111;
      4'hE: return hex ? 7'b0110000 : 7'b1111111;
      default: return hex ? 7'b0111000 : 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input bit blz, input bit hex);
    logic [15:0] up;
    up = v >> (4 * d);
    if (blz && d > 0 && up == 16'h0) return 7'b1111111;
    return seg_of(up[3:0], hex);
  endfunction

  // Monitor: on each frame pulse with a queued entry, check all 16 positions of that frame
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus_a.frame === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        for (int p = 0; p < 16; p++) begin
          int         d;
          bit         off;
          logic [3:0] ean;
          logic [6:0] sa, sbg;
          logic       edp;
          if (p > 0) @(negedge clock);
          d   = p / 4;
          off = e.off[p] || (p % 4 == 0);
          ean = off ? 4'b1111 : ~(4'b0001 << d);
          sa  = off ? 7'b1111111 : exp_seg(e.val, d, 1'b0, 1'b0);
          sbg = off ? 7'b1111111 : exp_seg(e.val, d, 1'b1, 1'b1);
          edp = off ? 1'b1 : ~e.dpv[d];
          check($sformatf("dec_v%h_p%0d", e.val, p),
                32'({bus_a.frame, bus_a.an, bus_a.seg, bus_a.dp}), 32'({p == 0, ean, sa, edp}));
          check($sformatf("hexlz_v%h_p%0d", e.val, p),
                32'({bus_b.frame, bus_b.an, bus_b.seg, bus_b.dp}), 32'({p == 0, ean, sbg, edp}));
        end
      end
    end
  end

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus_a.frame !== 1'b1 && n < 64);
    if (bus_a.frame !== 1'b1) check("frame_timeout", 32'(bus_a.frame), 32'd1);
  endtask

  task automatic next_frame();
    wait_frame();
    @(negedge clock);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic push(input logic [15:0] v, input logic [3:0] d, input logic [15:0] off);
    sb.push_back('{val: v, dpv: d, off: off});
  endtask

  task automatic check_off(input string name);
    check({name, "_a"}, 32'({bus_a.frame, bus_a.an, bus_a.seg, bus_a.dp}), 32'({1'b0, 4'hF, 7'h7F, 1'b1}));
    check({name, "_b"}, 32'({bus_b.frame, bus_b.an, bus_b.seg, bus_b.dp}), 32'({1'b0, 4'hF, 7'h7F, 1'b1}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; en = 1'b1; load = 1'b0; value = '0; dp_in = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_off("reset");

    // Release: first frame pulse on the 2nd cycle, then one every 16 cycles
    reset = 1'b0;
    @(negedge clock);
    check("first_frame", 32'(bus_a.frame), 32'd1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus_a.frame !== 1'b1 && n < 40);
    check("frame_period", 32'(n), 32'd16);

    next_frame(); do_load(16'h1234, 4'b0010); push(16'h1234, 4'b0010, 16'h0);
    next_frame(); do_load(16'h0070, 4'b0000); push(16'h0070, 4'b0000, 16'h0);
    next_frame(); do_load(16'h0000, 4'b0000); push(16'h0000, 4'b0000, 16'h0);
    next_frame(); do_load(16'h00AF, 4'b1001); push(16'h00AF, 4'b1001, 16'h0);

    // Newest load within a frame wins
    next_frame(); do_load(16'h1111, 4'b0000); do_load(16'h2222, 4'b0000); push(16'h2222, 4'b0000, 16'h0);

    // Load on the frame-end cycle overrides a pending value; pend must then be clear
    next_frame(); do_load(16'h5555, 4'b0000);
    repeat (12) @(negedge clock);
    do_load(16'h3333, 4'b0100);
    push(16'h3333, 4'b0100, 16'h0);
    push(16'h3333, 4'b0100, 16'h0);

    // en low for 5 cycles covering positions 2..6 of a frame
    next_frame();
    next_frame();
    push(16'h3333, 4'b0100, 16'b0000_0000_0111_1100);
    next_frame();
    en = 1'b0;
    repeat (5) @(negedge clock);
    en = 1'b1;

    // Reset while digit 2 is lit and a load is pending
    next_frame(); do_load(16'h7777, 4'b1111);
    repeat (7) @(negedge clock);
    check("pre_reset_an", 32'(bus_a.an), 32'(4'b1011));
    reset = 1'b1;
    @(negedge clock);
    check_off("mid_reset");
    repeat (2) @(negedge clock);
    push(16'h0000, 4'b0000, 16'h0);
    push(16'h0000, 4'b0000, 16'h0);
    reset = 1'b0;
    wait_frame();
    wait_frame();
    repeat (17) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
